// File: rtl/text_cmd_arbiter.sv
// text_cmd_arbiter: round-robin A/B arbiter issuing one setup/strobe/hold/ack cycle on the text command port per grant
module text_cmd_arbiter #(
  parameter bit BLANK_ONLY = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_blank,
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  logic       i_we_a,
  input  logic       i_we_b,
  input  logic [6:0] i_addr_a,
  input  logic [6:0] i_addr_b,
  input  logic [7:0] i_wdata_a,
  input  logic [7:0] i_wdata_b,
  output logic       o_ack_a,
  output logic       o_ack_b,
  output logic [7:0] o_rdata,
  output logic       o_busy,
  output logic       o_cmd_clk,
  output logic       o_cmd_we,
  output logic [6:0] o_cmd_addr,
  output logic [7:0] o_cmd_data,
  input  logic [7:0] i_cmd_rdata
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_t;
  state_t state;
  logic gnt_b, last_b, start, pick_b;
  always_comb begin
    start = (i_req_a | i_req_b) & (!BLANK_ONLY | i_blank);
    pick_b = i_req_b & (!i_req_a | !last_b);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      gnt_b <= 1'b0;
      last_b <= 1'b1;
      o_ack_a <= 1'b0;
      o_ack_b <= 1'b0;
      o_rdata <= 8'h00;
      o_busy <= 1'b0;
      o_cmd_clk <= 1'b0;
      o_cmd_we <= 1'b0;
      o_cmd_addr <= 7'h00;
      o_cmd_data <= 8'h00;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= SETUP;
          o_busy <= 1'b1;
          gnt_b <= pick_b;
          last_b <= pick_b;
          o_cmd_we <= pick_b ? i_we_b : i_we_a;
          o_cmd_addr <= pick_b ? i_addr_b : i_addr_a;
          o_cmd_data <= pick_b ? i_wdata_b : i_wdata_a;
        end
        SETUP: begin
          state <= STROBE;
          o_cmd_clk <= 1'b1;
        end
        STROBE: begin
          state <= HOLD;
          o_cmd_clk <= 1'b0;
        end
        HOLD: begin
          state <= ACK;
          o_rdata <= i_cmd_rdata;
          o_ack_a <= !gnt_b;
          o_ack_b <= gnt_b;
        end
        ACK: begin
          state <= IDLE;
          o_ack_a <= 1'b0;
          o_ack_b <= 1'b0;
          o_busy <= 1'b0;
          o_cmd_we <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_text_cmd_arbiter.sv
// tb_text_cmd_arbiter: scoreboard bench for text_cmd_arbiter in free-running and blank-gated modes
module tb_text_cmd_arbiter;
  logic i_clk = 1'b0, i_rst = 1'b1, i_blank = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, req_c = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [6:0] addr_a = 7'h00, addr_b = 7'h00;
  logic [7:0] wdata_a = 8'h00, wdata_b = 8'h00, cmd_rdata = 8'h00;
  logic ack_a, ack_b, busy, cmd_clk, cmd_we;
  logic [7:0] rdata, cmd_data;
  logic [6:0] cmd_addr;
  logic ack_a2, ack_b2, busy2, cmd_clk2, cmd_we2;
  logic [7:0] rdata2, cmd_data2;
  logic [6:0] cmd_addr2;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct {logic b; logic we; logic [6:0] addr; logic [7:0] data; logic [7:0] rdata;} exp_t;
  exp_t q[$], q2[$];
  int ack_cyc[$];
  logic model_last_b = 1'b1;

  text_cmd_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_blank(i_blank),
    .i_req_a(req_a), .i_req_b(req_b), .i_we_a(we_a), .i_we_b(we_b),
    .i_addr_a(addr_a), .i_addr_b(addr_b), .i_wdata_a(wdata_a), .i_wdata_b(wdata_b),
    .o_ack_a(ack_a), .o_ack_b(ack_b), .o_rdata(rdata), .o_busy(busy),
    .o_cmd_clk(cmd_clk), .o_cmd_we(cmd_we), .o_cmd_addr(cmd_addr), .o_cmd_data(cmd_data),
    .i_cmd_rdata(cmd_rdata)
  );

  text_cmd_arbiter #(.BLANK_ONLY(1'b1)) dut_blank (
    .i_clk(i_clk), .i_rst(i_rst), .i_blank(i_blank),
    .i_req_a(req_c), .i_req_b(1'b0), .i_we_a(we_a), .i_we_b(we_b),
    .i_addr_a(addr_a), .i_addr_b(addr_b), .i_wdata_a(wdata_a), .i_wdata_b(wdata_b),
    .o_ack_a(ack_a2), .o_ack_b(ack_b2), .o_rdata(rdata2), .o_busy(busy2),
    .o_cmd_clk(cmd_clk2), .o_cmd_we(cmd_we2), .o_cmd_addr(cmd_addr2), .o_cmd_data(cmd_data2),
    .i_cmd_rdata(cmd_rdata)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Round-robin reference: predicts the winner from the current request levels
  task automatic push_exp();
    exp_t e;
    logic pb;
    pb = req_b && (!req_a || !model_last_b);
    model_last_b = pb;
    e.b = pb;
    e.we = pb ? we_b : we_a;
    e.addr = pb ? addr_b : addr_a;
    e.data = pb ? wdata_b : wdata_a;
    e.rdata = cmd_rdata;
    q.push_back(e);
  endtask

  always @(negedge i_clk) if (!i_rst) begin
    exp_t e;
    if (cmd_clk) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL strobe_unexpected addr=%h data=%h we=%b", cmd_addr, cmd_data, cmd_we);
      end else if ({cmd_we, cmd_addr, cmd_data} !== {q[0].we, q[0].addr, q[0].data}) begin
        fails++;
        $display("FAIL strobe_fields got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                 cmd_we, cmd_addr, cmd_data, q[0].we, q[0].addr, q[0].data);
      end
    end
    if (ack_a || ack_b) begin
      ack_cyc.push_back(cyc);
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL ack_unexpected ack_a=%b ack_b=%b", ack_a, ack_b);
      end else begin
        e = q.pop_front();
        if ({ack_a, ack_b, rdata} !== {!e.b, e.b, e.rdata}) begin
          fails++;
          $display("FAIL ack got a=%b b=%b rdata=%h want a=%b b=%b rdata=%h",
                   ack_a, ack_b, rdata, !e.b, e.b, e.rdata);
        end
      end
    end
  end

  always @(negedge i_clk) if (!i_rst && (ack_a2 || ack_b2)) begin
    exp_t e;
    tests++;
    if (q2.size() == 0) begin
      fails++;
      $display("FAIL blank_ack_unexpected ack_a=%b ack_b=%b", ack_a2, ack_b2);
    end else begin
      e = q2.pop_front();
      if ({ack_a2, ack_b2, rdata2, cmd_addr2, cmd_data2} !== {1'b1, 1'b0, e.rdata, e.addr, e.data}) begin
        fails++;
        $display("FAIL blank_ack got a=%b b=%b rdata=%h addr=%h data=%h want a=1 b=0 rdata=%h addr=%h data=%h",
                 ack_a2, ack_b2, rdata2, cmd_addr2, cmd_data2, e.rdata, e.addr, e.data);
      end
    end
  end

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) tick();
    tests++;
    if ({ack_a, ack_b, busy, cmd_clk, cmd_we, cmd_addr, cmd_data, rdata} !== 35'h0) begin
      fails++;
      $display("FAIL reset_state got ack=%b%b busy=%b clk=%b we=%b addr=%h data=%h rdata=%h want all 0",
               ack_a, ack_b, busy, cmd_clk, cmd_we, cmd_addr, cmd_data, rdata);
    end
    i_rst = 1'b0;
    model_last_b = 1'b1;
    tick();
  endtask

  task automatic test_write_a();
    we_a = 1'b1; addr_a = 7'h46; wdata_a = 8'h62; req_a = 1'b1;
    push_exp();
    tick();
    tests++;
    if ({busy, cmd_clk} !== 2'b10) begin fails++; $display("FAIL write_setup got busy=%b clk=%b want 1 0", busy, cmd_clk); end
    tick();
    tests++;
    if (cmd_clk !== 1'b1) begin fails++; $display("FAIL write_strobe got clk=%b want 1", cmd_clk); end
    tick();
    tests++;
    if ({cmd_clk, ack_a} !== 2'b00) begin fails++; $display("FAIL write_hold got clk=%b ack=%b want 0 0", cmd_clk, ack_a); end
    tick();
    tests++;
    if ({ack_a, ack_b, cmd_we, cmd_addr} !== {3'b101, 7'h46}) begin
      fails++;
      $display("FAIL write_ack got a=%b b=%b we=%b addr=%h want 1 0 1 46", ack_a, ack_b, cmd_we, cmd_addr);
    end
    req_a = 1'b0;
    tick();
    tests++;
    if ({busy, ack_a, cmd_we} !== 3'b000) begin fails++; $display("FAIL write_done got busy=%b ack=%b we=%b want 0 0 0", busy, ack_a, cmd_we); end
  endtask

  task automatic test_read_b();
    logic we_seen = 1'b0;
    cmd_rdata = 8'h03; we_b = 1'b0; addr_b = 7'h48; wdata_b = 8'hA5; req_b = 1'b1;
    push_exp();
    repeat (4) begin
      tick();
      we_seen |= cmd_we;
    end
    tests++;
    if ({we_seen, ack_b, ack_a, rdata} !== {3'b010, 8'h03}) begin
      fails++;
      $display("FAIL read_b got we_seen=%b ack_b=%b ack_a=%b rdata=%h want 0 1 0 03", we_seen, ack_b, ack_a, rdata);
    end
    req_b = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    we_a = 1'b1; addr_a = 7'h10; wdata_a = 8'h11;
    we_b = 1'b0; addr_b = 7'h22; wdata_b = 8'h33; cmd_rdata = 8'h5A;
    req_a = 1'b1; req_b = 1'b1;
    repeat (6) push_exp();
    ack_cyc.delete();
    for (int i = 0; i < 60 && n < 6; i++) begin
      tick();
      if (ack_a || ack_b) n++;
      if (n == 6) begin req_a = 1'b0; req_b = 1'b0; end
    end
    req_a = 1'b0; req_b = 1'b0;
    tests++;
    if (n != 6) begin fails++; $display("FAIL b2b_count got %0d acks want 6", n); end
    repeat (8) tick();
    tests++;
    if (ack_cyc.size() != 6 || q.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain got acks=%0d pending=%0d want 6 0", ack_cyc.size(), q.size());
    end
    for (int i = 1; i < ack_cyc.size(); i++) begin
      tests++;
      if (ack_cyc[i] - ack_cyc[i-1] != 5) begin
        fails++;
        $display("FAIL b2b_spacing got %0d cycles want 5", ack_cyc[i] - ack_cyc[i-1]);
      end
    end
  endtask

  task automatic test_blank_only();
    exp_t e;
    logic strobe_seen = 1'b0;
    i_blank = 1'b0; we_a = 1'b1; addr_a = 7'h33; wdata_a = 8'h44; cmd_rdata = 8'h9C; req_c = 1'b1;
    repeat (20) begin
      tick();
      strobe_seen |= cmd_clk2 | busy2;
    end
    tests++;
    if (strobe_seen !== 1'b0) begin fails++; $display("FAIL blank_gate got activity=%b want 0", strobe_seen); end
    e.b = 1'b0; e.we = 1'b1; e.addr = 7'h33; e.data = 8'h44; e.rdata = 8'h9C;
    q2.push_back(e);
    i_blank = 1'b1;
    tick();
    tests++;
    if ({busy2, cmd_clk2} !== 2'b10) begin fails++; $display("FAIL blank_start got busy=%b clk=%b want 1 0", busy2, cmd_clk2); end
    tick();
    tests++;
    if (cmd_clk2 !== 1'b1) begin fails++; $display("FAIL blank_strobe got clk=%b want 1", cmd_clk2); end
    i_blank = 1'b0;
    tick();
    tick();
    tests++;
    if (ack_a2 !== 1'b1) begin fails++; $display("FAIL blank_ack_time got ack=%b want 1", ack_a2); end
    req_c = 1'b0;
    tick();
    tests++;
    if (q2.size() != 0 || busy2 !== 1'b0) begin fails++; $display("FAIL blank_done got pending=%0d busy=%b want 0 0", q2.size(), busy2); end
  endtask

  task automatic test_reset_mid();
    logic got = 1'b0;
    we_a = 1'b1; addr_a = 7'h55; wdata_a = 8'h66; req_a = 1'b1;
    push_exp();
    tick();
    tick();
    tests++;
    if (cmd_clk !== 1'b1) begin fails++; $display("FAIL rst_pre_strobe got clk=%b want 1", cmd_clk); end
    i_rst = 1'b1; req_a = 1'b0;
    tick();
    tests++;
    if ({cmd_clk, busy, ack_a, ack_b, cmd_addr} !== 11'h0) begin
      fails++;
      $display("FAIL rst_abort got clk=%b busy=%b ack=%b%b addr=%h want 0 0 00 00", cmd_clk, busy, ack_a, ack_b, cmd_addr);
    end
    q.delete();
    model_last_b = 1'b1;
    tick();
    i_rst = 1'b0;
    we_a = 1'b1; addr_a = 7'h0A; wdata_a = 8'hB0;
    we_b = 1'b1; addr_b = 7'h0B; wdata_b = 8'hB1;
    req_a = 1'b1; req_b = 1'b1;
    push_exp();
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ack_a || ack_b) begin
        got = 1'b1;
        tests++;
        if ({ack_a, ack_b} !== 2'b10) begin fails++; $display("FAIL rst_rr_restore got a=%b b=%b want 1 0", ack_a, ack_b); end
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    tests++;
    if (!got) begin fails++; $display("FAIL rst_rr_timeout got no ack want ack within 20 cycles"); end
    repeat (2) tick();
  endtask

  task automatic test_req_drop();
    we_a = 1'b1; addr_a = 7'h3A; wdata_a = 8'h7E; req_a = 1'b1;
    push_exp();
    tick();
    req_a = 1'b0; addr_a = 7'h7F; wdata_a = 8'h00; we_a = 1'b0;
    tick();
    tick();
    tick();
    tests++;
    if ({ack_a, cmd_addr, cmd_data, cmd_we} !== {1'b1, 7'h3A, 8'h7E, 1'b1}) begin
      fails++;
      $display("FAIL req_drop got ack=%b addr=%h data=%h we=%b want 1 3a 7e 1", ack_a, cmd_addr, cmd_data, cmd_we);
    end
    tick();
    tests++;
    if ({busy, ack_a, cmd_addr} !== {2'b00, 7'h3A}) begin
      fails++;
      $display("FAIL req_drop_idle got busy=%b ack=%b addr=%h want 0 0 3a", busy, ack_a, cmd_addr);
    end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_b();
    test_back_to_back();
    test_blank_only();
    test_reset_mid();
    test_req_drop();
    repeat (6) tick();
    tests++;
    if (q.size() != 0 || q2.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover got %0d/%0d pending want 0/0", q.size(), q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
